// File: rtl/seq_mult_hs.sv
// seq_mult_hs: radix-2 shift-add multiplier with valid/ready handshakes; define SEQ_MULT_SIGNED_EN for signed mode
module seq_mult_hs #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               op_signed,
`endif
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d, mq_q, mq_d, acc_q, acc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod_raw, prod_fin;
  logic [WIDTH-1:0]     a_mag, b_mag;
  assign sum      = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_raw = {sum, mq_q[WIDTH-1:1]};
`ifdef SEQ_MULT_SIGNED_EN
  logic sign_q, sign_d;
  assign a_mag    = (op_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign b_mag    = (op_signed && multiplier[WIDTH-1]) ? -multiplier : multiplier;
  assign sign_d   = (state_q == IDLE && in_valid) ? op_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]) : sign_q;
  assign prod_fin = sign_q ? -prod_raw : prod_raw;
  // sign of the result, captured with the operands
  always_ff @(posedge clk)
    sign_q <= reset ? 1'b0 : sign_d;
`else
  assign a_mag    = multiplicand;
  assign b_mag    = multiplier;
  assign prod_fin = prod_raw;
`endif
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign product   = product_q;
  // next state: accept operands, shift-add one multiplier bit per cycle, hold result until taken
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mq_d      = mq_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        mcand_d = a_mag;
        mq_d    = b_mag;
        acc_d   = '0;
        count_d = '0;
      end
      RUN: begin
        acc_d   = sum[WIDTH:1];
        mq_d    = {sum[0], mq_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d   = DONE;
          product_d = prod_fin;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mq_q      <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mq_q      <= mq_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end
endmodule

// File: tb/tb_seq_mult_hs.sv
// tb_seq_mult_hs: directed checks of seq_mult_hs against a transaction-level model
module tb_seq_mult_hs;
  localparam int W = 16;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1, op_signed = 0;
  logic [W-1:0] multiplicand = '0, multiplier = '0;
  logic in_ready, busy, out_valid;
  logic [2*W-1:0] product;
  int tests = 0, fails = 0;
  bit started = 0, m_run = 0, m_valid = 0;
  int m_left = 0;
  logic [2*W-1:0] m_prod = '0, m_pend = '0;

  seq_mult_hs #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(multiplicand), .multiplier(multiplier),
`ifdef SEQ_MULT_SIGNED_EN
    .op_signed(op_signed),
`endif
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint p;
    p = s ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
    return p[2*W-1:0];
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // transaction model: accept in idle, result appears W cycles later, held until taken
  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      m_run = 0; m_valid = 0; m_left = 0; m_prod = '0;
    end else if (m_run) begin
      m_left--;
      if (m_left == 0) begin m_run = 0; m_valid = 1; m_prod = m_pend; end
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (in_valid) begin
      m_run = 1; m_left = W; m_pend = ref_mul(multiplicand, multiplier, op_signed);
    end
  end

  always @(negedge clk) if (started) begin
    check("cmp_in_ready", 32'(in_ready), 32'(!m_run && !m_valid));
    check("cmp_busy", 32'(busy), 32'(m_run || m_valid));
    check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
    check("cmp_product", product, m_prod);
  end

  task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [31:0] exp, input int stall, input string nm);
    int n;
    multiplicand = a; multiplier = b; op_signed = s; in_valid = 1; out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 0; multiplicand = 16'($urandom); multiplier = 16'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    check({nm, " latency"}, 32'(n), 32'(W));
    check({nm, " product"}, product, exp);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1;
      @(posedge clk); #1;
      check({nm, " stall in_ready"}, 32'(in_ready), 32'd0);
      check({nm, " stall product"}, product, exp);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    check({nm, " idle in_ready"}, 32'(in_ready), 32'd1);
    check({nm, " idle out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int t, hs1, hs2;
    logic [31:0] p1, p2;
    logic prev;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset product", product, 32'd0);
    reset = 0;
    mult(16'd3, 16'd5, 0, 32'h0000000F, 0, "3x5");
    mult(16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001, 0, "ffff_sq");
    mult(16'h1234, 16'd0, 0, 32'h0, 0, "zero_b");
    mult(16'd7, 16'd9, 0, 32'h0000003F, 10, "7x9_stall");
    multiplicand = 16'hABCD; multiplier = 16'h1111; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1; in_valid = 1; multiplicand = 16'd9; multiplier = 16'd9;
    @(posedge clk); #1;
    reset = 0; in_valid = 0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort product", product, 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    mult(16'd2, 16'd3, 0, 32'h6, 0, "post_abort");
    multiplicand = 16'd2; multiplier = 16'd3; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    multiplicand = 16'd4; multiplier = 16'd5;
    t = 0; hs1 = -1; hs2 = -1; p1 = '0; p2 = '0; prev = 0;
    while (hs2 < 0 && t < 60) begin
      @(posedge clk); #1; t++;
      if (out_valid && !prev) begin
        if (hs1 < 0) begin hs1 = t + 1; p1 = product; end
        else begin hs2 = t + 1; p2 = product; in_valid = 0; end
      end
      prev = out_valid;
    end
    in_valid = 0;
    check("b2b first cycle", 32'(hs1), 32'd17);
    check("b2b first product", p1, 32'h6);
    check("b2b second cycle", 32'(hs2), 32'd35);
    check("b2b second product", p2, 32'h14);
    repeat (2) @(posedge clk);
    #1;
`ifdef SEQ_MULT_SIGNED_EN
    mult(16'hFFFD, 16'd5, 1, 32'hFFFFFFF1, 0, "neg3x5");
    mult(16'h8000, 16'h8000, 1, 32'h40000000, 0, "minneg_sq");
    mult(16'h8000, 16'h8000, 0, 32'h40000000, 0, "8000_sq_unsigned");
    mult(16'h0005, 16'hFFFF, 1, 32'hFFFFFFFB, 0, "5xneg1");
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
